// File: rtl/lfsr_checker.sv
// Receive-side checker for the on-chip XNOR LFSR: seeds a local generator from the
// incoming stream, verifies it, then flywheels and counts mispredicted words.
module lfsr_checker #(
  parameter int                  NUM_BITS   = 32,
  parameter logic [NUM_BITS-1:0] TAPS       = 32'h80200003,
  parameter int                  LOCK_COUNT = 4,
  parameter int                  MISS_LIMIT = 3,
  parameter int                  ERR_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [ERR_W-1:0]    o_Err_Count,
  output logic                o_Stuck
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int SW = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] MISS_LAST  = SW'(MISS_LIMIT - 1);

  function automatic logic [NUM_BITS-1:0] step_lfsr(input logic [NUM_BITS-1:0] s);
    return {s[NUM_BITS-2:0], ~^(s & TAPS)};
  endfunction

  logic [1:0]          state;
  logic [NUM_BITS-1:0] pred;
  logic [MW-1:0]       match_cnt;
  logic [SW-1:0]       miss_cnt;

  logic                ones;
  logic                hit;
  logic [NUM_BITS-1:0] seed_next;
  logic [NUM_BITS-1:0] pred_next;

  assign ones      = &i_LFSR_Data;
  assign hit       = (i_LFSR_Data == pred);
  assign seed_next = step_lfsr(i_LFSR_Data);
  assign pred_next = step_lfsr(pred);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= SEARCH;
      pred        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      o_Locked    <= 1'b0;
      o_Error     <= 1'b0;
      o_Err_Count <= '0;
      o_Stuck     <= 1'b0;
    end else begin
      o_Error <= 1'b0;
      if (i_Clear_Count) o_Err_Count <= '0;
      if (i_Valid) begin
        case (state)
          SEARCH: begin
            if (ones) begin
              o_Stuck <= 1'b1;
            end else begin
              pred      <= seed_next;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              pred <= seed_next;
              if (match_cnt == MATCH_LAST) begin
                state    <= LOCKED;
                o_Locked <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (ones) begin
              o_Stuck <= 1'b1;
              state   <= SEARCH;
            end else begin
              // Resync on the offending word rather than dropping back to search.
              pred      <= seed_next;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            pred <= pred_next;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              o_Error <= 1'b1;
              // Clear takes effect before the increment, so a clear+error leaves 1.
              if (i_Clear_Count)   o_Err_Count <= ERR_W'(1);
              else if (~&o_Err_Count) o_Err_Count <= o_Err_Count + 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state    <= SEARCH;
                o_Locked <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= SEARCH;
            o_Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
